// File: rtl/qspi_pad_arbiter_pkg.sv
// Shared types and constants for the QSPI pad-group arbiter.
package qspi_arb_pkg;

   typedef enum logic [1:0] {ARB_IDLE, ARB_GUARD, ARB_GRANT} arb_state_e;

   localparam logic MST_NATV = 1'b0;
   localparam logic MST_APB  = 1'b1;

   function automatic logic [1:0] mst_onehot(input logic mst);
      return mst ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/qspi_pad_arbiter_if.sv
// Request/grant bundle between the pad arbiter and the two QSPI controllers, sysctrl and pad mux.
interface qspi_pad_arbiter_if #(
   parameter int unsigned CNT_W = 16
);
   logic             mode_i;
   logic             static_sel_i;
   logic [1:0]       req_i;
   logic [1:0]       nss_i;
   logic [1:0]       gnt_o;
   logic             sel_o;
   logic             pad_hold_o;
   logic             busy_o;
   logic [CNT_W-1:0] sw_cnt_o;

   // Arbiter side
   modport slave (
      input  mode_i, static_sel_i, req_i, nss_i,
      output gnt_o, sel_o, pad_hold_o, busy_o, sw_cnt_o
   );

   // Controller / sysctrl / pad-mux side
   modport master (
      output mode_i, static_sel_i, req_i, nss_i,
      input  gnt_o, sel_o, pad_hold_o, busy_o, sw_cnt_o
   );
endinterface

// File: rtl/qspi_pad_arbiter.sv
// Sequenced handover of the shared QSPI pad group: the old transfer must finish (nss high)
// and the pads must sit idle for a guard interval before the next owner is granted.
module qspi_pad_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int unsigned GUARD_CYCLES = 4,
   parameter int unsigned CNT_W        = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   qspi_pad_arbiter_if.slave bus
);

   localparam int unsigned GW = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;

   arb_state_e       state, state_n;
   logic [GW-1:0]    cnt, cnt_n;
   logic [1:0]       gnt, gnt_n;
   logic             sel, sel_n;
   logic             hold, hold_n;
   logic             busy;
   logic             last, last_n;
   logic [CNT_W-1:0] swc, swc_n;
   logic [1:0]       eff_req;
   logic             winner;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= ARB_IDLE;
         cnt   <= '0;
         gnt   <= '0;
         sel   <= MST_NATV;
         hold  <= 1'b1;
         busy  <= 1'b0;
         last  <= MST_APB;
         swc   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         gnt   <= gnt_n;
         sel   <= sel_n;
         hold  <= hold_n;
         busy  <= (state_n != ARB_IDLE);
         last  <= last_n;
         swc   <= swc_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gnt_n   = gnt;
      sel_n   = sel;
      hold_n  = hold;
      last_n  = last;
      swc_n   = swc;
      eff_req = bus.mode_i ? bus.req_i : (bus.static_sel_i ? 2'b10 : 2'b01);
      winner  = (eff_req == 2'b11) ? ~last : eff_req[1];

      unique case (state)
         ARB_IDLE: begin
            if (|eff_req) begin
               sel_n = winner;
               if (GUARD_CYCLES == 0) begin
                  state_n = ARB_GRANT;
                  gnt_n   = mst_onehot(winner);
                  hold_n  = 1'b0;
               end else begin
                  state_n = ARB_GUARD;
                  cnt_n   = GW'(GUARD_CYCLES);
               end
            end
         end
         // Counts down to zero and grants on the following edge, so the grant
         // lands GUARD_CYCLES+1 edges after the request was taken in IDLE.
         ARB_GUARD: begin
            if (!eff_req[sel]) begin
               state_n = ARB_IDLE;
            end else if (cnt == '0) begin
               state_n = ARB_GRANT;
               gnt_n   = mst_onehot(sel);
               hold_n  = 1'b0;
            end else begin
               cnt_n = cnt - GW'(1);
            end
         end
         ARB_GRANT: begin
            if (!eff_req[sel] && bus.nss_i[sel]) begin
               state_n = ARB_IDLE;
               gnt_n   = '0;
               hold_n  = 1'b1;
               last_n  = sel;
               if (swc != '1) swc_n = swc + CNT_W'(1);
            end
         end
         default: begin
            state_n = ARB_IDLE;
            gnt_n   = '0;
            hold_n  = 1'b1;
         end
      endcase
   end

   assign bus.gnt_o      = gnt;
   assign bus.sel_o      = sel;
   assign bus.pad_hold_o = hold;
   assign bus.busy_o     = busy;
   assign bus.sw_cnt_o   = swc;

endmodule

// File: tb/tb_qspi_pad_arbiter.sv
// Directed bench: guarded build (GUARD=4, 16-bit counter) and no-guard build (3-bit counter).
module tb_qspi_pad_arbiter;
   import qspi_arb_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   qspi_pad_arbiter_if #(.CNT_W(16)) if0 ();
   qspi_pad_arbiter_if #(.CNT_W(3))  if1 ();

   qspi_pad_arbiter #(.GUARD_CYCLES(4), .CNT_W(16)) dut0 (
      .clk_i(clk), .rst_i(rst), .bus(if0)
   );
   qspi_pad_arbiter #(.GUARD_CYCLES(0), .CNT_W(3)) dut1 (
      .clk_i(clk), .rst_i(rst), .bus(if1)
   );

   task automatic tick(input int unsigned n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_g0(input string tag, input logic [1:0] gnt, input logic sel,
                           input logic hold);
      check({tag, ".gnt"},  32'(if0.gnt_o),      32'(gnt));
      check({tag, ".sel"},  32'(if0.sel_o),      32'(sel));
      check({tag, ".hold"}, 32'(if0.pad_hold_o), 32'(hold));
   endtask

   logic m;

   initial begin
      if0.mode_i = 1'b1; if0.static_sel_i = 1'b0; if0.req_i = 2'b00; if0.nss_i = 2'b11;
      if1.mode_i = 1'b1; if1.static_sel_i = 1'b0; if1.req_i = 2'b00; if1.nss_i = 2'b11;

      // Reset values
      tick(2);
      check_g0("rst", 2'b00, 1'b0, 1'b1);
      check("rst.busy", 32'(if0.busy_o), 32'd0);
      check("rst.cnt",  32'(if0.sw_cnt_o), 32'd0);
      check("rst1.hold", 32'(if1.pad_hold_o), 32'd1);
      check("rst1.cnt",  32'(if1.sw_cnt_o), 32'd0);

      // 1: single request, grant at edge 5
      rst = 1'b0;
      if0.req_i = 2'b01;
      tick();
      check_g0("t1.e0", 2'b00, 1'b0, 1'b1);
      check("t1.busy", 32'(if0.busy_o), 32'd1);
      tick(4);
      check_g0("t1.e4", 2'b00, 1'b0, 1'b1);
      tick();
      check_g0("t1.e5", 2'b01, 1'b0, 1'b0);

      // 2: req drops while nss low; grant held until nss rises
      if0.nss_i = 2'b10;
      if0.req_i = 2'b00;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t2.hold_gnt", 32'(if0.gnt_o), 32'h1);
      end
      if0.nss_i = 2'b11;
      tick();
      check_g0("t2.rel", 2'b00, 1'b0, 1'b1);
      check("t2.cnt",  32'(if0.sw_cnt_o), 32'd1);
      check("t2.busy", 32'(if0.busy_o), 32'd0);

      // 3: both request; round robin alternates (last=0 -> master 1 first)
      if0.req_i = 2'b11;
      m = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check_g0("t3.pick", 2'b00, m, 1'b1);
         for (int g = 0; g < 4; g++) begin
            tick();
            check_g0("t3.guard", 2'b00, m, 1'b1);
         end
         tick();
         check_g0("t3.gnt", mst_onehot(m), m, 1'b0);
         if0.nss_i[m] = 1'b0;
         tick(3);
         check("t3.xfer", 32'(if0.gnt_o), 32'(mst_onehot(m)));
         if0.req_i[m] = 1'b0;
         if0.nss_i[m] = 1'b1;
         tick();
         check_g0("t3.rel", 2'b00, m, 1'b1);
         check("t3.cnt", 32'(if0.sw_cnt_o), 32'(k + 2));
         if0.req_i[m] = 1'b1;
         m = ~m;
      end
      if0.req_i = 2'b00;

      // 4: static mode, select flips mid-transfer
      if0.mode_i = 1'b0;
      if0.static_sel_i = 1'b0;
      tick(6);
      check_g0("t4.gnt0", 2'b01, 1'b0, 1'b0);
      if0.nss_i = 2'b10;
      if0.static_sel_i = 1'b1;
      tick(3);
      check_g0("t4.held", 2'b01, 1'b0, 1'b0);
      if0.nss_i = 2'b11;
      tick();
      check_g0("t4.rel", 2'b00, 1'b0, 1'b1);
      check("t4.cnt", 32'(if0.sw_cnt_o), 32'd6);
      tick();
      check_g0("t4.pick", 2'b00, 1'b1, 1'b1);
      tick(4);
      check_g0("t4.guard", 2'b00, 1'b1, 1'b1);
      tick();
      check_g0("t4.gnt1", 2'b10, 1'b1, 1'b0);
      if0.mode_i = 1'b1;
      if0.req_i = 2'b00;
      tick();
      check_g0("t4.rel1", 2'b00, 1'b1, 1'b1);
      check("t4.cnt1", 32'(if0.sw_cnt_o), 32'd7);

      // 5: request withdrawn during guard
      if0.req_i = 2'b10;
      tick(2);
      check("t5.busy", 32'(if0.busy_o), 32'd1);
      if0.req_i = 2'b00;
      tick();
      check_g0("t5.abort", 2'b00, 1'b1, 1'b1);
      check("t5.idle", 32'(if0.busy_o), 32'd0);
      tick(5);
      check_g0("t5.never", 2'b00, 1'b1, 1'b1);
      check("t5.cnt", 32'(if0.sw_cnt_o), 32'd7);

      // 6: reset during grant
      if0.req_i = 2'b01;
      tick(6);
      check_g0("t6.gnt", 2'b01, 1'b0, 1'b0);
      if0.nss_i = 2'b10;
      rst = 1'b1;
      tick();
      check_g0("t6.rst", 2'b00, 1'b0, 1'b1);
      check("t6.cnt",  32'(if0.sw_cnt_o), 32'd0);
      check("t6.busy", 32'(if0.busy_o), 32'd0);
      rst = 1'b0;
      if0.req_i = 2'b00;
      if0.nss_i = 2'b11;

      // No-guard build: one-cycle grant latency and counter saturation
      for (int i = 1; i <= 9; i++) begin
         if1.req_i = (i % 2 == 0) ? 2'b10 : 2'b01;
         tick();
         check("g0.gnt", 32'(if1.gnt_o), (i % 2 == 0) ? 32'h2 : 32'h1);
         check("g0.hold", 32'(if1.pad_hold_o), 32'd0);
         if1.req_i = 2'b00;
         tick();
         check("g0.rel", 32'(if1.gnt_o), 32'h0);
         check("g0.cnt", 32'(if1.sw_cnt_o), (i > 7) ? 32'd7 : 32'(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
